// File: rtl/spi_pixel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_pixel_receiver
// Purpose  : Receives pixels from a quad/multi-line SPI-style link clocked by
//            the peripheral (dclk), oversampled in the clk_in domain. Each
//            completed word is presented with a one-cycle strobe and the
//            raster position (hcount/vcount) of that pixel.
// Options  : define SPI_RX_FRAME_CHECK_EN to compare the peripheral's tlast
//            tag against the local raster position and flag misalignment.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pixel_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4,
  parameter int H_PIXELS   = 1280,
  parameter int V_PIXELS   = 720
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  chip_clk_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_sel_in,
  input  logic                  final_pixel_in,
  output logic                  pixel_valid_out,
  output logic [DATA_WIDTH-1:0] pixel_data_out,
  output logic [10:0]           hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  frame_err_out
);

  localparam int                BEATS     = DATA_WIDTH / LINES;
  localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [10:0]       H_LAST    = 11'(H_PIXELS - 1);
  localparam logic [9:0]        V_LAST    = 10'(V_PIXELS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  // Two-stage synchronizers, identical depth so data stays aligned to dclk
  logic [1:0]       dclk_sync;
  logic [1:0]       cs_sync;
  logic [1:0]       final_sync;
  logic [LINES-1:0] data_meta;
  logic [LINES-1:0] data_sync;
  logic             dclk_prev;

  logic             dclk_s;
  logic             cs_s;
  logic             final_s;
  logic [LINES-1:0] data_s;
  logic             dclk_rise;

  logic [0:0]        state;
  logic [BEAT_W-1:0] beat;
  logic              shift_en;
  logic              word_done;

  logic [DATA_WIDTH-1:0] assembled;

  // Position of the next word to complete
  logic [10:0] col;
  logic [9:0]  row;
  logic [10:0] col_next;
  logic [9:0]  row_next;

  // Synchronize all link inputs; cs idles high so its stages reset to 1
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dclk_sync  <= 2'b00;
      cs_sync    <= 2'b11;
      final_sync <= 2'b00;
      data_meta  <= '0;
      data_sync  <= '0;
    end else begin
      dclk_sync  <= {dclk_sync[0], chip_clk_in};
      cs_sync    <= {cs_sync[0], chip_sel_in};
      final_sync <= {final_sync[0], final_pixel_in};
      data_meta  <= chip_data_in;
      data_sync  <= data_meta;
    end
  end

  assign dclk_s  = dclk_sync[1];
  assign cs_s    = cs_sync[1];
  assign final_s = final_sync[1];
  assign data_s  = data_sync;

  // Remember the previous synchronized dclk level for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dclk_prev <= 1'b0;
    end else begin
      dclk_prev <= dclk_s;
    end
  end

  assign dclk_rise = dclk_s & ~dclk_prev;
  assign shift_en  = (state == RECV) && !cs_s && dclk_rise;
  assign word_done = shift_en && (beat == LAST_BEAT);

  // Link FSM and beat counter; cs high in RECV drops any partial word
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (!cs_s) begin
            state <= RECV;
          end
        end
        RECV: begin
          if (cs_s) begin
            state <= IDLE;
            beat  <= '0;
          end else if (dclk_rise) begin
            if (beat == LAST_BEAT) begin
              beat <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  // Word assembly: earlier beats sit in a shift register, newest beat is LSBs
  generate
    if (BEATS > 1) begin : g_multi_beat
      logic [DATA_WIDTH-LINES-1:0] partial;

      // Shift each received beat in, MSB-first overall
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          partial <= '0;
        end else if (shift_en) begin
          partial <= assembled[DATA_WIDTH-LINES-1:0];
        end
      end

      assign assembled = {partial, data_s};
    end else begin : g_single_beat
      assign assembled = data_s;
    end
  endgenerate

`ifdef SPI_RX_FRAME_CHECK_EN
  logic at_last;
  logic frame_err;

  assign at_last = (col == H_LAST) && (row == V_LAST);

  // Sticky error when the tlast tag disagrees with the local raster position
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_err <= 1'b0;
    end else if (word_done && (final_s != at_last)) begin
      frame_err <= 1'b1;
    end
  end

  assign frame_err_out = frame_err;
`else
  logic unused_final;

  assign unused_final  = final_s;
  assign frame_err_out = 1'b0;
`endif

  // Raster advance; a premature tlast restarts the frame when checking is on
  always_comb begin
    col_next = col + 11'd1;
    row_next = row;
    if (col == H_LAST) begin
      col_next = 11'd0;
      row_next = (row == V_LAST) ? 10'd0 : row + 10'd1;
    end
`ifdef SPI_RX_FRAME_CHECK_EN
    if (final_s && !at_last) begin
      col_next = 11'd0;
      row_next = 10'd0;
    end
`endif
  end

  // Track the position of the next pixel to arrive
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col <= 11'd0;
      row <= 10'd0;
    end else if (word_done) begin
      col <= col_next;
      row <= row_next;
    end
  end

  // Present each completed pixel with a single-cycle strobe
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_valid_out <= 1'b0;
      pixel_data_out  <= '0;
      hcount_out      <= 11'd0;
      vcount_out      <= 10'd0;
    end else begin
      pixel_valid_out <= word_done;
      if (word_done) begin
        pixel_data_out <= assembled;
        hcount_out     <= col;
        vcount_out     <= row;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_pixel_receiver
// Purpose  : Self-checking bench for spi_pixel_receiver using a reduced raster
//            so that full-frame and wrap behaviour fit a short run. Expected
//            positions come from a pixel-index model (index mod H / div H).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_pixel_receiver;

  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int H     = 16;
  localparam int V     = 6;
  localparam int BEATS = DW / LN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dclk = 1'b0;
  logic [LN-1:0] dat = '0;
  logic          cs = 1'b1;
  logic          fin = 1'b0;

  logic          valid;
  logic [DW-1:0] pdata;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          err;

  spi_pixel_receiver #(
    .DATA_WIDTH (DW),
    .LINES      (LN),
    .H_PIXELS   (H),
    .V_PIXELS   (V)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .chip_clk_in     (dclk),
    .chip_data_in    (dat),
    .chip_sel_in     (cs),
    .final_pixel_in  (fin),
    .pixel_valid_out (valid),
    .pixel_data_out  (pdata),
    .hcount_out      (hcount),
    .vcount_out      (vcount),
    .frame_err_out   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe monitor, sampled on the falling edge
  int            strobes = 0;
  int            cap_cyc = 0;
  logic [DW-1:0] cap_d = '0;
  int            cap_h = 0;
  int            cap_v = 0;
  logic          cap_err = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      strobes++;
      cap_cyc = cyc;
      cap_d   = pdata;
      cap_h   = int'(hcount);
      cap_v   = int'(vcount);
      cap_err = err;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raster position as a linear pixel index
  int m_col = 0;
  int m_row = 0;
  bit m_err = 1'b0;
  int exp_strobes = 0;
  int last_rise_cyc = 0;

  task automatic check(input string name, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_advance();
    int idx;
    idx   = (m_row * H + m_col + 1) % (H * V);
    m_col = idx % H;
    m_row = idx / H;
  endtask

  task automatic model_pixel(input bit tag);
    bit at_last;
    at_last = (m_col == H - 1) && (m_row == V - 1);
`ifdef SPI_RX_FRAME_CHECK_EN
    if (tag && !at_last) begin
      m_err = 1'b1;
      m_col = 0;
      m_row = 0;
    end else begin
      if (!tag && at_last) m_err = 1'b1;
      model_advance();
    end
`else
    if (tag || at_last) begin
      // tag has no effect without frame checking
    end
    model_advance();
`endif
  endtask

  task automatic send_beat(input logic [LN-1:0] v);
    @(negedge clk);
    dat = v;
    repeat ($urandom_range(3, 5)) @(negedge clk);
    dclk = 1'b1;
    last_rise_cyc = cyc;
    repeat ($urandom_range(3, 5)) @(negedge clk);
    dclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input bit tag);
    int ex_h;
    int ex_v;
    ex_h = m_col;
    ex_v = m_row;
    model_pixel(tag);
    exp_strobes++;
    fin = tag;
    for (int b = 0; b < BEATS; b++) send_beat(d[DW-1-b*LN -: LN]);
    for (int i = 0; i < 40 && strobes < exp_strobes; i++) @(negedge clk);
    fin = 1'b0;
    check("strobe_count", strobes, exp_strobes);
    check("pixel_data", cap_d, d);
    check("hcount", cap_h, ex_h);
    check("vcount", cap_v, ex_v);
    check("frame_err", cap_err, m_err);
  endtask

  initial begin
    logic [DW-1:0] rnd;
    int            base;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", pdata, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Nothing may be received while cs is high
    send_beat(4'hF);
    send_beat(4'hF);
    repeat (6) @(negedge clk);
    check("idle_no_strobe", strobes, 0);

    // Single pixel 0xA5 at (0,0), strobe one cycle after synchronized edge
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_pixel(8'hA5, 1'b0);
    check("latency", cap_cyc - last_rise_cyc, 3);

    // Abort mid-word, then a full word
    send_beat(4'h7);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    send_pixel(8'h3C, 1'b0);

    // Random stream crossing two line wraps
    for (int n = 0; n < 2 * H + 3; n++) begin
      rnd = DW'($urandom);
      send_pixel(rnd, 1'b0);
    end

    // Asynchronous reset mid-word
    send_beat(4'h9);
    @(negedge clk);
    rst_n = 1'b0;
    cs = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_data", pdata, 0);
    check("arst_hcount", hcount, 0);
    check("arst_vcount", vcount, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_col = 0;
    m_row = 0;
    m_err = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    // Full frame, tlast on the final pixel
    base = strobes;
    for (int n = 0; n < H * V; n++) begin
      rnd = DW'($urandom);
      send_pixel(rnd, n == H * V - 1);
    end
    check("frame_strobes", strobes - base, H * V);
    check("frame_last_h", cap_h, H - 1);
    check("frame_last_v", cap_v, V - 1);
    check("frame_err_clean", cap_err, 0);

    // Premature tlast on pixel (5,0)
    for (int n = 0; n < 5; n++) send_pixel(DW'(n + 1), 1'b0);
    send_pixel(8'h55, 1'b1);
    send_pixel(8'h66, 1'b0);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("tlast_err", err, 1);
    check("tlast_next_h", cap_h, 0);
`else
    check("tlast_err", err, 0);
    check("tlast_next_h", cap_h, 6);
`endif
    check("tlast_next_v", cap_v, 0);

    repeat (10) @(negedge clk);
    check("total_strobes", strobes, exp_strobes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
